// File: rtl/exp_pkg.sv
// Shared types and elaboration/helper arithmetic for the fixed-point exp unit.
// Helpers work on 64-bit longint, so DATA_W up to 32 keeps every intermediate exact.
package exp_pkg;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    // round(2^frac_w / k!), rounding half up
    function automatic longint coef(input int k, input int frac_w);
        longint fact;
        longint one;
        fact = 1;
        one  = longint'(1) <<< frac_w;
        for (int i = 2; i <= k; i++) fact = fact * i;
        return (one + fact / 2) / fact;
    endfunction

    function automatic longint clamp64(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // clamp to the signed range of a w-bit word
    function automatic longint sat64(input longint v, input int w);
        longint hi;
        hi = (longint'(1) <<< (w - 1)) - 1;
        return clamp64(v, -hi - 1, hi);
    endfunction

endpackage

// File: rtl/exp_taylor_fx_if.sv
// Input/output valid-ready handshake bundle of the exp unit.
interface exp_taylor_fx_if #(parameter int DATA_W = 32);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/exp_horner_step.sv
// One Horner step: sat_W((acc * x) >>> FRAC_W + coef), flagging when saturation clipped.
module exp_horner_step
    import exp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic signed [DATA_W-1:0] acc,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] coef,
    output logic signed [DATA_W-1:0] result,
    output logic                     sat
);
    logic signed [2*DATA_W-1:0] acc_w;
    logic signed [2*DATA_W-1:0] x_w;
    logic signed [2*DATA_W-1:0] prod;
    longint                     sum;
    longint                     clipped;

    always_comb begin
        acc_w   = {{DATA_W{acc[DATA_W-1]}}, acc};
        x_w     = {{DATA_W{x[DATA_W-1]}}, x};
        prod    = acc_w * x_w;
        // arithmetic shift floors toward -inf
        sum     = longint'(prod >>> FRAC_W) + longint'(coef);
        clipped = sat64(sum, DATA_W);
        sat     = (clipped != sum);
        result  = clipped[DATA_W-1:0];
    end
endmodule

// File: rtl/exp_taylor_fx.sv
// Fixed-point e^x as an ORDER-term Taylor polynomial, one Horner multiply-add per cycle.
module exp_taylor_fx
    import exp_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FRAC_W    = 16,
    parameter int ORDER     = 3,
    parameter int INPUT_MAX = 5
) (
    input  logic           clk,
    input  logic           rst,
    exp_taylor_fx_if.slave bus
);
    localparam int     CNT_W = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam longint LIM   = longint'(INPUT_MAX) <<< FRAC_W;

    state_t                   state, state_nxt;
    logic signed [DATA_W-1:0] acc;
    logic signed [DATA_W-1:0] x_reg;
    logic        [CNT_W-1:0]  cnt;
    logic                     sat_reg;

    logic signed [DATA_W-1:0] coef_tab [ORDER+1];
    logic signed [DATA_W-1:0] coef_sel;
    logic signed [DATA_W-1:0] step_res;
    logic                     step_sat;
    logic                     last;

    longint                   x_wide;
    longint                   x_clip;
    logic signed [DATA_W-1:0] x_clamped;
    logic                     in_sat;

    for (genvar k = 0; k <= ORDER; k++) begin : g_coef
        assign coef_tab[k] = DATA_W'(coef(k, FRAC_W));
    end

    assign coef_sel = coef_tab[cnt];
    assign last     = (cnt == '0);

    always_comb begin
        x_wide    = longint'(bus.in_data);
        x_clip    = clamp64(x_wide, -LIM, LIM);
        x_clamped = x_clip[DATA_W-1:0];
        in_sat    = (x_clip != x_wide);
    end

    exp_horner_step #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_step (
        .acc    (acc),
        .x      (x_reg),
        .coef   (coef_sel),
        .result (step_res),
        .sat    (step_sat)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = ITER;
            ITER:    if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // handshake outputs
    always_comb begin
        bus.in_ready  = (state == IDLE) && !rst;
        bus.out_valid = (state == DONE);
    end

    // datapath; the final step folds in the [0, max] output clamp
    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            x_reg        <= '0;
            cnt          <= '0;
            sat_reg      <= 1'b0;
            bus.out_data <= '0;
            bus.out_sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    x_reg   <= x_clamped;
                    sat_reg <= in_sat;
                    acc     <= coef_tab[ORDER];
                    cnt     <= CNT_W'(ORDER - 1);
                end
                ITER: if (last) begin
                    bus.out_data <= step_res[DATA_W-1] ? '0 : step_res;
                    bus.out_sat  <= sat_reg | step_sat | step_res[DATA_W-1];
                end else begin
                    acc     <= step_res;
                    sat_reg <= sat_reg | step_sat;
                    cnt     <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exp_taylor_fx.sv
// Directed-vector bench for exp_taylor_fx at DATA_W=32, FRAC_W=16, ORDER=3.
module tb_exp_taylor_fx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    exp_taylor_fx_if #(.DATA_W(32)) bus ();

    exp_taylor_fx #(
        .DATA_W    (32),
        .FRAC_W    (16),
        .ORDER     (3),
        .INPUT_MAX (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] x;
        logic [31:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // Accept x, wait for out_valid, compare, then complete the transfer after `stall` low cycles.
    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] exp_d,
                          input logic exp_s, input int stall);
        int          lat;
        logic        stable;
        logic [31:0] held;
        @(negedge clk);
        check({name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = x;
        bus.out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hDEAD_BEEF;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({name, ".latency"}, 32'(lat), 32'd3);
        check({name, ".data"}, bus.out_data, exp_d);
        check({name, ".sat"}, 32'(bus.out_sat), 32'(exp_s));
        if (stall > 0) begin
            stable = 1'b1;
            held   = bus.out_data;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (!bus.out_valid || bus.in_ready || bus.out_data !== held || bus.out_sat !== exp_s)
                    stable = 1'b0;
            end
            check({name, ".stall_stable"}, 32'(stable), 32'd1);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check({name, ".post_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, ".post_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{"zero",     32'h0000_0000, 32'h0001_0000, 1'b0};
        vecs[1] = '{"one",      32'h0001_0000, 32'h0002_AAAB, 1'b0};
        vecs[2] = '{"neg_one",  32'hFFFF_0000, 32'h0000_5555, 1'b0};
        vecs[3] = '{"half",     32'h0000_8000, 32'h0001_A555, 1'b0};
        vecs[4] = '{"neg_half", 32'hFFFF_8000, 32'h0000_9AAA, 1'b0};
        vecs[5] = '{"five",     32'h0005_0000, 32'h0027_557F, 1'b0};
        vecs[6] = '{"ten_clmp", 32'h000A_0000, 32'h0027_557F, 1'b1};
        vecs[7] = '{"neg_five", 32'hFFFB_0000, 32'h0000_0000, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        check("rst.in_ready",  32'(bus.in_ready),  32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_data",  bus.out_data,       32'd0);
        check("rst.out_sat",   32'(bus.out_sat),   32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].x, vecs[i].exp_data, vecs[i].exp_sat, 0);

        run_op("stall10", 32'hFFFF_0000, 32'h0000_5555, 1'b0, 10);

        // reset during the second ITER cycle discards the operation
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0001_0000;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (bus.out_valid) seen = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end
            check("midrst.no_valid", 32'(seen), 32'd0);
        end
        check("midrst.out_data", bus.out_data,     32'd0);
        check("midrst.out_sat",  32'(bus.out_sat), 32'd0);
        run_op("after_rst", 32'h0001_0000, 32'h0002_AAAB, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end
endmodule
